aes_req_arbiter: RTL and testbench

//   Shares one AES-128 encryptor (aes_top: start/busy/done/fault_flag interface) among NREQ clients.

---
 rtl/aes_req_arbiter_pkg.sv | 13 +
 rtl/aes_req_arbiter_rr_pick.sv | 31 +++
 rtl/aes_req_arbiter.sv | 111 +++++++++++
 tb/tb_aes_req_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_req_arbiter_pkg.sv
// rtl/aes_req_arbiter_pkg.sv - shared widths and FSM state encoding for the AES request arbiter
package aes_req_arbiter_pkg;

  localparam int AES_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/aes_req_arbiter_rr_pick.sv
// rtl/aes_req_arbiter_rr_pick.sv - combinational rotate-priority picker, scanning from ptr+1
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] cand;

  // The last-served client (ptr) is examined last, giving round-robin fairness.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// rtl/aes_req_arbiter.sv - round-robin sharing of one AES-128 encryptor among NREQ clients
module aes_req_arbiter
  import aes_req_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*128-1:0] req_key,
  input  logic [NREQ*128-1:0] req_pt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [127:0]      rsp_data,
  output logic              rsp_fault,
  output logic              rsp_timeout,
  output logic [7:0]        fault_cnt,
  output logic              aes_start,
  output logic [127:0]      aes_key,
  output logic [127:0]      aes_pt,
  input  logic              aes_busy,
  input  logic              aes_done,
  input  logic [127:0]      aes_ct,
  input  logic              aes_fault
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  arb_state_e      state;
  logic [IDW-1:0]  ptr;
  logic [TW-1:0]   timer;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign req_ready = (state == ST_IDLE) ? grant : '0;
  // Start is held back while the encryptor still drains an abandoned job.
  assign aes_start = (state == ST_ISSUE) && !aes_busy;
  assign rsp_valid = (state == ST_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= IDW'(NREQ - 1);
      timer       <= '0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      rsp_fault   <= 1'b0;
      rsp_timeout <= 1'b0;
      fault_cnt   <= '0;
      aes_key     <= '0;
      aes_pt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            aes_key <= req_key[pick_idx*AES_W +: AES_W];
            aes_pt  <= req_pt[pick_idx*AES_W +: AES_W];
            rsp_id  <= pick_idx;
            ptr     <= pick_idx;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!aes_busy) begin
            timer <= '0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          timer <= timer + 1'b1;
          // A done arriving on the watchdog's last cycle still counts as a completion.
          if (aes_done) begin
            rsp_data    <= aes_fault ? '0 : aes_ct;
            rsp_fault   <= aes_fault;
            rsp_timeout <= 1'b0;
            state       <= ST_RESP;
            if (aes_fault && fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
          end else if (timer == TIMER_LAST) begin
            rsp_data    <= '0;
            rsp_fault   <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= ST_RESP;
            if (fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb/tb_aes_req_arbiter.sv - directed bench for aes_req_arbiter with a behavioural encryptor model
module tb_aes_req_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TO   = 64;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*128-1:0]  req_key;
  logic [NREQ*128-1:0]  req_pt;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [IDW-1:0]       rsp_id;
  logic [127:0]         rsp_data;
  logic                 rsp_fault;
  logic                 rsp_timeout;
  logic [7:0]           fault_cnt;
  logic                 aes_start;
  logic [127:0]         aes_key;
  logic [127:0]         aes_pt;
  logic                 aes_busy = 1'b0;
  logic                 aes_done = 1'b0;
  logic [127:0]         aes_ct = '0;
  logic                 aes_fault = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  aes_req_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_pt(req_pt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_fault(rsp_fault), .rsp_timeout(rsp_timeout), .fault_cnt(fault_cnt),
    .aes_start(aes_start), .aes_key(aes_key), .aes_pt(aes_pt),
    .aes_busy(aes_busy), .aes_done(aes_done), .aes_ct(aes_ct), .aes_fault(aes_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] key_of(input int i);
    if (i == 2) return K1;
    return {4{32'h11110000 + 32'(i)}};
  endfunction

  function automatic logic [127:0] pt_of(input int i);
    if (i == 2) return P1;
    return {4{32'hA0A00000 + 32'(i)}};
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] k, input logic [127:0] p);
    if (k == K1 && p == P1) return CT1;
    return k ^ {p[63:0], p[127:64]} ^ {4{32'h5a5a1234}};
  endfunction

  // Encryptor model: mode 0 ok, 1 fault, 2 stays busy m_hang cycles and never signals done.
  int m_mode = 0, m_cur = 0, m_lat = 3, m_hang = 100, m_cnt = 0;
  logic [127:0] m_key = '0, m_pt = '0;
  always @(posedge clk) begin
    aes_done  <= 1'b0;
    aes_fault <= 1'b0;
    if (aes_start) begin
      aes_busy <= 1'b1;
      m_cnt    <= 1;
      m_key    <= aes_key;
      m_pt     <= aes_pt;
      m_cur    <= m_mode;
    end else if (aes_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cur == 2) begin
        if (m_cnt == m_hang - 1) aes_busy <= 1'b0;
      end else if (m_cnt == m_lat - 1) begin
        aes_busy  <= 1'b0;
        aes_done  <= 1'b1;
        aes_fault <= (m_cur == 1);
        aes_ct    <= (m_cur == 1) ? {4{32'hdeadbeef}} : enc(m_key, m_pt);
      end
    end
  end

  task automatic do_reset;
    int n = 0;
    while (aes_busy && n < 300) begin @(negedge clk); n++; end
    @(negedge clk);
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    int n = 0;
    while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
    ok = rsp_valid;
  endtask

  task automatic handshake;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if ({rsp_id, rsp_fault, rsp_timeout} !== '0) begin n_bad++; $display("FAIL reset_rsp_flags: got %b want 0", {rsp_id, rsp_fault, rsp_timeout}); end
    n_cmp++; if (rsp_data !== '0) begin n_bad++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    n_cmp++; if (fault_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_fault_cnt: got %0d want 0", fault_cnt); end
    n_cmp++; if (aes_start !== 1'b0) begin n_bad++; $display("FAIL reset_aes_start: got %b want 0", aes_start); end
    n_cmp++; if ({aes_key, aes_pt} !== '0) begin n_bad++; $display("FAIL reset_aes_regs: got %h want 0", {aes_key, aes_pt}); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
  endtask

  task automatic test_single_client;
    int n = 0, s;
    bit ok;
    do_reset();
    m_mode = 0; m_lat = 3;
    req_valid = 4'b0100;
    #1;
    while (req_ready == '0 && n < 10) begin @(negedge clk); n++; end
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_grant: got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    n_cmp++; if (aes_start !== 1'b1) begin n_bad++; $display("FAIL single_start_latency: got %b want 1", aes_start); end
    n_cmp++; if (aes_key !== K1 || aes_pt !== P1) begin n_bad++; $display("FAIL single_key_pt: got %h/%h want %h/%h", aes_key, aes_pt, K1, P1); end
    s = cyc;
    wait_rsp(ok);
    n_cmp++; if (!ok || cyc - s != 4) begin n_bad++; $display("FAIL single_rsp_latency: got %0d want 4", cyc - s); end
    n_cmp++; if (rsp_id !== 2'd2) begin n_bad++; $display("FAIL single_rsp_id: got %0d want 2", rsp_id); end
    n_cmp++; if (rsp_data !== CT1) begin n_bad++; $display("FAIL single_rsp_data: got %h want %h", rsp_data, CT1); end
    n_cmp++; if ({rsp_fault, rsp_timeout} !== 2'b00) begin n_bad++; $display("FAIL single_rsp_status: got %b want 00", {rsp_fault, rsp_timeout}); end
    handshake();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_rsp_release: got %b want 0", rsp_valid); end
  endtask

  task automatic test_round_robin;
    int order[5];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int got = 0, n = 0, bad_hot = 0, bad_long = 0;
    bit prev = 0;
    do_reset();
    m_mode = 0; m_lat = 3;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    #1;
    while (got < 5 && n < 200) begin
      if (req_ready != '0) begin
        if ($countones(req_ready) != 1) bad_hot++;
        if (prev) bad_long++;
        for (int b = 0; b < NREQ; b++) if (req_ready[b]) order[got] = b;
        got++;
        prev = 1;
      end else begin
        prev = 0;
      end
      @(negedge clk); n++;
      if (got == 5) req_valid = '0;
    end
    n_cmp++; if (got != 5) begin n_bad++; $display("FAIL rr_accept_count: got %0d want 5", got); end
    n_cmp++; if (bad_hot != 0) begin n_bad++; $display("FAIL rr_onehot: got %0d bad grants want 0", bad_hot); end
    n_cmp++; if (bad_long != 0) begin n_bad++; $display("FAIL rr_single_cycle: got %0d long grants want 0", bad_long); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (got > i && order[i] != exp_order[i]) begin n_bad++; $display("FAIL rr_order_%0d: got %0d want %0d", i, order[i], exp_order[i]); end
    end
    repeat (20) @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int bad = 0;
    bit ok;
    logic [127:0] exp_d;
    do_reset();
    m_mode = 0; m_lat = 3;
    exp_d = enc(key_of(1), pt_of(1));
    req_valid = 4'b1010;
    wait_rsp(ok);
    n_cmp++; if (!ok || rsp_id !== 2'd1) begin n_bad++; $display("FAIL bp_first_id: got %0d want 1", rsp_id); end
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== 2'd1 || req_ready !== '0) bad++;
      @(negedge clk);
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    handshake();
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL bp_next_grant: got %b want 1000", req_ready); end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(ok);
    n_cmp++; if (!ok || rsp_id !== 2'd3 || rsp_data !== enc(key_of(3), pt_of(3))) begin n_bad++; $display("FAIL bp_second_rsp: got id %0d data %h want id 3", rsp_id, rsp_data); end
    handshake();
  endtask

  task automatic test_fault_count;
    int hs = 0, n = 0;
    bit ok;
    do_reset();
    m_mode = 1; m_lat = 3;
    req_valid = 4'b0001;
    wait_rsp(ok);
    n_cmp++; if (!ok || {rsp_fault, rsp_timeout} !== 2'b10) begin n_bad++; $display("FAIL fault_status: got %b want 10", {rsp_fault, rsp_timeout}); end
    n_cmp++; if (rsp_data !== '0) begin n_bad++; $display("FAIL fault_data: got %h want 0", rsp_data); end
    n_cmp++; if (fault_cnt !== 8'd1) begin n_bad++; $display("FAIL fault_cnt_first: got %0d want 1", fault_cnt); end
    rsp_ready = 1'b1;
    while (hs < 300 && n < 6000) begin
      if (rsp_valid) begin
        hs++;
        if (hs == 300) req_valid = '0;
      end
      @(negedge clk); n++;
    end
    rsp_ready = 1'b0;
    n_cmp++; if (hs != 300) begin n_bad++; $display("FAIL fault_jobs: got %0d want 300", hs); end
    n_cmp++; if (fault_cnt !== 8'd255) begin n_bad++; $display("FAIL fault_cnt_sat: got %0d want 255", fault_cnt); end
    m_mode = 0;
  endtask

  task automatic test_done_wins;
    int n = 0, s;
    bit ok;
    do_reset();
    m_mode = 0; m_lat = TO;
    req_valid = 4'b0001;
    while (!aes_start && n < 10) begin @(negedge clk); n++; end
    s = cyc;
    req_valid = '0;
    wait_rsp(ok);
    n_cmp++; if (!ok || cyc - s != TO + 1) begin n_bad++; $display("FAIL edge_done_latency: got %0d want %0d", cyc - s, TO + 1); end
    n_cmp++; if ({rsp_fault, rsp_timeout} !== 2'b00 || rsp_data !== enc(key_of(0), pt_of(0))) begin n_bad++; $display("FAIL edge_done_wins: got %b %h want 00", {rsp_fault, rsp_timeout}, rsp_data); end
    handshake();
  endtask

  task automatic test_timeout;
    int n = 0, s, s2;
    bit ok;
    do_reset();
    m_mode = 2; m_hang = 100;
    req_valid = 4'b0100;
    while (!aes_start && n < 10) begin @(negedge clk); n++; end
    s = cyc;
    req_valid = '0;
    wait_rsp(ok);
    n_cmp++; if (!ok || cyc - s != TO + 1) begin n_bad++; $display("FAIL to_latency: got %0d want %0d", cyc - s, TO + 1); end
    n_cmp++; if ({rsp_fault, rsp_timeout} !== 2'b11 || rsp_data !== '0) begin n_bad++; $display("FAIL to_status: got %b %h want 11 0", {rsp_fault, rsp_timeout}, rsp_data); end
    n_cmp++; if (fault_cnt !== 8'd1 || rsp_id !== 2'd2) begin n_bad++; $display("FAIL to_cnt_id: got %0d %0d want 1 2", fault_cnt, rsp_id); end
    m_mode = 0; m_lat = 3;
    req_valid = 4'b1000;
    handshake();
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL to_next_grant: got %b want 1000", req_ready); end
    @(negedge clk);
    req_valid = '0;
    n = 0;
    while (!aes_start && n < 100) begin @(negedge clk); n++; end
    s2 = cyc;
    n_cmp++; if (!aes_start || s2 - s != m_hang) begin n_bad++; $display("FAIL to_start_after_busy: got %0d want %0d", s2 - s, m_hang); end
    wait_rsp(ok);
    n_cmp++; if (!ok || rsp_id !== 2'd3 || rsp_timeout !== 1'b0) begin n_bad++; $display("FAIL to_followup: got id %0d to %b want 3 0", rsp_id, rsp_timeout); end
    handshake();
  endtask

  task automatic test_reset_mid;
    int n = 0;
    bit ok;
    do_reset();
    m_mode = 0; m_lat = TO;
    req_valid = 4'b0010;
    while (!aes_start && n < 10) begin @(negedge clk); n++; end
    req_valid = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if ({rsp_valid, aes_start, rsp_fault, rsp_timeout, rsp_id} !== '0) begin n_bad++; $display("FAIL mid_reset_flags: got %b want 0", {rsp_valid, aes_start, rsp_fault, rsp_timeout, rsp_id}); end
    n_cmp++; if ({aes_key, aes_pt, rsp_data} !== '0 || fault_cnt !== 8'd0 || req_ready !== '0) begin n_bad++; $display("FAIL mid_reset_regs: got %h %0d want 0", aes_key, fault_cnt); end
    req_valid = 4'hF;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_reset_first_grant: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(ok);
    n_cmp++; if (!ok || rsp_id !== 2'd0 || rsp_timeout !== 1'b0 || rsp_data !== enc(key_of(0), pt_of(0))) begin n_bad++; $display("FAIL mid_reset_job: got id %0d to %b data %h", rsp_id, rsp_timeout, rsp_data); end
    handshake();
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      req_key[128*i +: 128] = key_of(i);
      req_pt[128*i +: 128]  = pt_of(i);
    end
    test_reset();
    test_single_client();
    test_round_robin();
    test_backpressure();
    test_fault_count();
    test_done_wins();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
